// File: rtl/phase_gen_pkg.sv
// Shared widths, state encoding and configuration record for the phase generator.
// cfg_t is laid out at the package default widths.
package phase_gen_pkg;

  localparam int unsigned PHASE_DW_DEF = 16;
  localparam int unsigned ACC_DW_DEF   = 32;
  localparam int unsigned CNT_DW_DEF   = 16;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_e;

  typedef struct packed {
    logic [ACC_DW_DEF-1:0]   freq;
    logic [ACC_DW_DEF-1:0]   step;
    logic [CNT_DW_DEF-1:0]   sweep_len;
    logic [PHASE_DW_DEF-1:0] offset;
  } cfg_t;

endpackage

// File: rtl/phase_sweep_ctrl.sv
// Chirp controller: tracks the current frequency word, the in-sweep sample
// count and the end-of-sweep flag, advancing once per load event.
module phase_sweep_ctrl
  import phase_gen_pkg::*;
#(
  parameter int unsigned ACC_DW = ACC_DW_DEF,
  parameter int unsigned CNT_DW = CNT_DW_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load_i,
  input  logic              apply_i,
  input  logic [ACC_DW-1:0] new_freq_i,
  input  logic [ACC_DW-1:0] new_step_i,
  input  logic [CNT_DW-1:0] new_len_i,
  input  logic [ACC_DW-1:0] act_freq_i,
  input  logic [ACC_DW-1:0] act_step_i,
  input  logic [CNT_DW-1:0] act_len_i,
  output logic [ACC_DW-1:0] freq_eff_o,
  output logic              last_o
);

  localparam logic [CNT_DW-1:0] CNT_ONE = CNT_DW'(1);

  logic [ACC_DW-1:0] freq_cur_q, freq_cur_d;
  logic [CNT_DW-1:0] cnt_q, cnt_d;
  logic              last_q, last_d;

  logic [ACC_DW-1:0] freq_eff, start_eff, step_eff;
  logic [CNT_DW-1:0] len_eff, cnt_eff;

  always_comb begin
    // A freshly applied config restarts the sweep from its own start word.
    freq_eff   = apply_i ? new_freq_i : freq_cur_q;
    start_eff  = apply_i ? new_freq_i : act_freq_i;
    step_eff   = apply_i ? new_step_i : act_step_i;
    len_eff    = apply_i ? new_len_i  : act_len_i;
    cnt_eff    = apply_i ? '0         : cnt_q;
    freq_cur_d = freq_cur_q;
    cnt_d      = cnt_q;
    last_d     = last_q;
    if (load_i) begin
      if (len_eff == '0) begin
        freq_cur_d = freq_eff;
        cnt_d      = '0;
        last_d     = 1'b0;
      end else if (cnt_eff == len_eff - CNT_ONE) begin
        freq_cur_d = start_eff;
        cnt_d      = '0;
        last_d     = 1'b1;
      end else begin
        freq_cur_d = freq_eff + step_eff;
        cnt_d      = cnt_eff + CNT_ONE;
        last_d     = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      freq_cur_q <= '0;
      cnt_q      <= '0;
      last_q     <= 1'b0;
    end else begin
      freq_cur_q <= freq_cur_d;
      cnt_q      <= cnt_d;
      last_q     <= last_d;
    end
  end

  assign freq_eff_o = freq_eff;
  assign last_o     = last_q;

endmodule

// File: rtl/phase_gen.sv
// Phase-accumulator AXI-Stream source with constant and chirp modes,
// shadowed configuration applied only at sample boundaries.
module phase_gen
  import phase_gen_pkg::*;
#(
  parameter int unsigned PHASE_DW = PHASE_DW_DEF,
  parameter int unsigned ACC_DW   = ACC_DW_DEF,
  parameter int unsigned CNT_DW   = CNT_DW_DEF
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                enable,
  input  logic                phase_reset,
  input  logic                cfg_load,
  input  logic [ACC_DW-1:0]   cfg_freq,
  input  logic [ACC_DW-1:0]   cfg_step,
  input  logic [CNT_DW-1:0]   cfg_sweep_len,
  input  logic [PHASE_DW-1:0] cfg_offset,
  output logic                cfg_pending,
  output logic [PHASE_DW-1:0] m_axis_phase_tdata,
  output logic                m_axis_phase_tvalid,
  input  logic                m_axis_phase_tready,
  output logic                m_axis_phase_tlast
);

  state_e              state_q, state_d;
  cfg_t                shadow_q, shadow_d, active_q, active_d;
  logic                pending_q, pending_d;
  logic                preset_q, preset_d;
  logic [ACC_DW-1:0]   acc_q, acc_d;
  logic [PHASE_DW-1:0] tdata_q, tdata_d;
  logic                tvalid_q, tvalid_d;

  logic                load, apply, handshake;
  logic [ACC_DW-1:0]   acc_eff, freq_eff;
  logic [PHASE_DW-1:0] offset_eff;

  always_comb begin
    handshake  = tvalid_q & m_axis_phase_tready;
    load       = enable & (~tvalid_q | m_axis_phase_tready);
    apply      = load & pending_q;
    acc_eff    = preset_q ? '0 : acc_q;
    offset_eff = pending_q ? shadow_q.offset : active_q.offset;

    state_d = state_q;
    case (state_q)
      IDLE:    if (enable) state_d = RUN;
      RUN:     if (!enable && (!tvalid_q || handshake)) state_d = IDLE;
      default: state_d = IDLE;
    endcase

    shadow_d = shadow_q;
    if (cfg_load) begin
      shadow_d.freq      = cfg_freq;
      shadow_d.step      = cfg_step;
      shadow_d.sweep_len = cfg_sweep_len;
      shadow_d.offset    = cfg_offset;
    end
    // A capture coinciding with an apply keeps pending set for the next event.
    pending_d = cfg_load | (pending_q & ~load);
    preset_d  = phase_reset | (preset_q & ~load);
    active_d  = apply ? shadow_q : active_q;

    acc_d    = acc_q;
    tdata_d  = tdata_q;
    tvalid_d = tvalid_q;
    if (load) begin
      tdata_d  = acc_eff[ACC_DW-1 -: PHASE_DW] + offset_eff;
      acc_d    = acc_eff + freq_eff;
      tvalid_d = 1'b1;
    end else if (handshake) begin
      tvalid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      shadow_q  <= '0;
      active_q  <= '0;
      pending_q <= 1'b0;
      preset_q  <= 1'b0;
      acc_q     <= '0;
      tdata_q   <= '0;
      tvalid_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      shadow_q  <= shadow_d;
      active_q  <= active_d;
      pending_q <= pending_d;
      preset_q  <= preset_d;
      acc_q     <= acc_d;
      tdata_q   <= tdata_d;
      tvalid_q  <= tvalid_d;
    end
  end

  phase_sweep_ctrl #(
    .ACC_DW(ACC_DW),
    .CNT_DW(CNT_DW)
  ) u_sweep (
    .clk        (clk),
    .reset      (reset),
    .load_i     (load),
    .apply_i    (apply),
    .new_freq_i (shadow_q.freq),
    .new_step_i (shadow_q.step),
    .new_len_i  (shadow_q.sweep_len),
    .act_freq_i (active_q.freq),
    .act_step_i (active_q.step),
    .act_len_i  (active_q.sweep_len),
    .freq_eff_o (freq_eff),
    .last_o     (m_axis_phase_tlast)
  );

  assign cfg_pending         = pending_q;
  assign m_axis_phase_tdata  = tdata_q;
  assign m_axis_phase_tvalid = tvalid_q;

endmodule

// File: tb/tb_phase_gen.sv
// Directed bench for phase_gen: table-driven streams plus hand-written
// stall/reconfiguration and mid-stream reset sequences.
module tb_phase_gen;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        enable = 1'b0;
  logic        phase_reset = 1'b0;
  logic        cfg_load = 1'b0;
  logic [31:0] cfg_freq = '0;
  logic [31:0] cfg_step = '0;
  logic [15:0] cfg_sweep_len = '0;
  logic [15:0] cfg_offset = '0;
  logic        cfg_pending;
  logic [15:0] tdata;
  logic        tvalid;
  logic        tready = 1'b0;
  logic        tlast;

  int unsigned tests = 0;
  int unsigned failed = 0;

  typedef struct {
    logic        en;
    logic        rdy;
    logic [15:0] data;
    logic        valid;
    logic        last;
  } vec_t;

  vec_t tbl[$];

  phase_gen #(
    .PHASE_DW(16),
    .ACC_DW  (32),
    .CNT_DW  (16)
  ) dut (
    .clk                 (clk),
    .reset               (reset),
    .enable              (enable),
    .phase_reset         (phase_reset),
    .cfg_load            (cfg_load),
    .cfg_freq            (cfg_freq),
    .cfg_step            (cfg_step),
    .cfg_sweep_len       (cfg_sweep_len),
    .cfg_offset          (cfg_offset),
    .cfg_pending         (cfg_pending),
    .m_axis_phase_tdata  (tdata),
    .m_axis_phase_tvalid (tvalid),
    .m_axis_phase_tready (tready),
    .m_axis_phase_tlast  (tlast)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    reset = 1'b1; enable = 1'b0; tready = 1'b0; phase_reset = 1'b0; cfg_load = 1'b0;
    tick();
    tick();
    reset = 1'b0;
    chk("rst_tvalid", {31'd0, tvalid}, 32'd0);
    chk("rst_tdata", {16'd0, tdata}, 32'd0);
    chk("rst_tlast", {31'd0, tlast}, 32'd0);
    chk("rst_pending", {31'd0, cfg_pending}, 32'd0);
  endtask

  task automatic load_cfg(input logic [31:0] f, input logic [31:0] s,
                          input logic [15:0] len, input logic [15:0] off);
    cfg_freq = f; cfg_step = s; cfg_sweep_len = len; cfg_offset = off;
    cfg_load = 1'b1;
    tick();
    cfg_load = 1'b0;
    chk("cfg_pending_set", {31'd0, cfg_pending}, 32'd1);
  endtask

  task automatic run_range(input string tag, input int lo, input int hi);
    for (int i = lo; i <= hi; i++) begin
      enable = tbl[i].en;
      tready = tbl[i].rdy;
      tick();
      chk($sformatf("%s[%0d].tdata", tag, i), {16'd0, tdata}, {16'd0, tbl[i].data});
      chk($sformatf("%s[%0d].tvalid", tag, i), {31'd0, tvalid}, {31'd0, tbl[i].valid});
      chk($sformatf("%s[%0d].tlast", tag, i), {31'd0, tlast}, {31'd0, tbl[i].last});
    end
  endtask

  initial begin
    // constant 0x0100_0000: indices 0..3
    tbl.push_back('{1'b1, 1'b1, 16'h0000, 1'b1, 1'b0});
    tbl.push_back('{1'b1, 1'b1, 16'h0100, 1'b1, 1'b0});
    tbl.push_back('{1'b1, 1'b1, 16'h0200, 1'b1, 1'b0});
    tbl.push_back('{1'b1, 1'b1, 16'h0300, 1'b1, 1'b0});
    // backpressure on 0x0200: indices 4..11
    tbl.push_back('{1'b1, 1'b1, 16'h0000, 1'b1, 1'b0});
    tbl.push_back('{1'b1, 1'b1, 16'h0100, 1'b1, 1'b0});
    tbl.push_back('{1'b1, 1'b1, 16'h0200, 1'b1, 1'b0});
    tbl.push_back('{1'b1, 1'b0, 16'h0200, 1'b1, 1'b0});
    tbl.push_back('{1'b1, 1'b0, 16'h0200, 1'b1, 1'b0});
    tbl.push_back('{1'b1, 1'b0, 16'h0200, 1'b1, 1'b0});
    tbl.push_back('{1'b1, 1'b1, 16'h0300, 1'b1, 1'b0});
    tbl.push_back('{1'b1, 1'b1, 16'h0400, 1'b1, 1'b0});
    // chirp, sweep_len 4: indices 12..19
    tbl.push_back('{1'b1, 1'b1, 16'h0000, 1'b1, 1'b0});
    tbl.push_back('{1'b1, 1'b1, 16'h0001, 1'b1, 1'b0});
    tbl.push_back('{1'b1, 1'b1, 16'h0003, 1'b1, 1'b0});
    tbl.push_back('{1'b1, 1'b1, 16'h0006, 1'b1, 1'b1});
    tbl.push_back('{1'b1, 1'b1, 16'h000A, 1'b1, 1'b0});
    tbl.push_back('{1'b1, 1'b1, 16'h000B, 1'b1, 1'b0});
    tbl.push_back('{1'b1, 1'b1, 16'h000D, 1'b1, 1'b0});
    tbl.push_back('{1'b1, 1'b1, 16'h0010, 1'b1, 1'b1});
    // offset 0x8000 with wrap: indices 20..24
    tbl.push_back('{1'b1, 1'b1, 16'h8000, 1'b1, 1'b0});
    tbl.push_back('{1'b1, 1'b1, 16'hC000, 1'b1, 1'b0});
    tbl.push_back('{1'b1, 1'b1, 16'h0000, 1'b1, 1'b0});
    tbl.push_back('{1'b1, 1'b1, 16'h4000, 1'b1, 1'b0});
    tbl.push_back('{1'b1, 1'b1, 16'h8000, 1'b1, 1'b0});

    // 1: constant frequency, then a handshake with enable low drops tvalid
    do_reset();
    load_cfg(32'h0100_0000, 32'd0, 16'd0, 16'h0000);
    chk("t1_idle_tvalid", {31'd0, tvalid}, 32'd0);
    run_range("t1", 0, 3);
    chk("t1_pending_clr", {31'd0, cfg_pending}, 32'd0);
    enable = 1'b0; tready = 1'b1;
    tick();
    chk("t1_drain_tvalid", {31'd0, tvalid}, 32'd0);
    tick();
    chk("t1_idle2_tvalid", {31'd0, tvalid}, 32'd0);

    // 2: backpressure
    do_reset();
    load_cfg(32'h0100_0000, 32'd0, 16'd0, 16'h0000);
    run_range("t2", 4, 11);

    // 3: chirp
    do_reset();
    load_cfg(32'h0001_0000, 32'h0001_0000, 16'd4, 16'h0000);
    run_range("t3", 12, 19);

    // 4: offset and wrap
    do_reset();
    load_cfg(32'h4000_0000, 32'd0, 16'd0, 16'h8000);
    run_range("t4", 20, 24);

    // 5: phase_reset + cfg_load during a stall, with enable briefly dropped
    do_reset();
    load_cfg(32'h0100_0000, 32'd0, 16'd0, 16'h0000);
    enable = 1'b1; tready = 1'b1;
    tick();
    tick();
    chk("t5_pre_tdata", {16'd0, tdata}, 32'h0100);
    tready = 1'b0;
    tick();
    chk("t5_stall_tdata", {16'd0, tdata}, 32'h0100);
    phase_reset = 1'b1; cfg_load = 1'b1;
    cfg_freq = 32'h0100_0000; cfg_step = '0; cfg_sweep_len = '0; cfg_offset = 16'h1234;
    enable = 1'b0;
    tick();
    phase_reset = 1'b0; cfg_load = 1'b0;
    chk("t5_held_tdata", {16'd0, tdata}, 32'h0100);
    chk("t5_held_tvalid", {31'd0, tvalid}, 32'd1);
    chk("t5_pending", {31'd0, cfg_pending}, 32'd1);
    enable = 1'b1;
    tick();
    chk("t5_held2_tdata", {16'd0, tdata}, 32'h0100);
    tready = 1'b1;
    tick();
    chk("t5_apply_tdata", {16'd0, tdata}, 32'h1234);
    chk("t5_apply_tvalid", {31'd0, tvalid}, 32'd1);
    chk("t5_pending_clr", {31'd0, cfg_pending}, 32'd0);
    tick();
    chk("t5_next_tdata", {16'd0, tdata}, 32'h1334);

    // 6: reset mid-stream while stalled, then re-enable without config
    do_reset();
    load_cfg(32'h0100_0000, 32'd0, 16'd0, 16'h0000);
    enable = 1'b1; tready = 1'b1;
    tick();
    tick();
    tready = 1'b0;
    cfg_freq = 32'h0200_0000; cfg_load = 1'b1;
    tick();
    cfg_load = 1'b0;
    chk("t6_stall_tvalid", {31'd0, tvalid}, 32'd1);
    chk("t6_stall_tdata", {16'd0, tdata}, 32'h0100);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("t6_rst_tvalid", {31'd0, tvalid}, 32'd0);
    chk("t6_rst_tdata", {16'd0, tdata}, 32'd0);
    chk("t6_rst_pending", {31'd0, cfg_pending}, 32'd0);
    tready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk($sformatf("t6_re[%0d].tdata", k), {16'd0, tdata}, 32'h0000);
      chk($sformatf("t6_re[%0d].tvalid", k), {31'd0, tvalid}, 32'd1);
    end

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
